// File: rtl/hiscore_pkg.sv
// Shared types for the hiscore engine: FSM states, buffer depth, byte index.
package hiscore_pkg;

  typedef enum logic [2:0] {IDLE, PAUSE, WR, RD_ADDR, RD_CAP, DONE} hs_state_t;

  localparam int HS_BUF_MAX = 64;

  typedef logic [5:0] hs_idx_t;

endpackage

// File: rtl/hiscore_buf.sv
// Hiscore byte buffer: 64x8 register file.
// One write port shared by ioctl download (idle) and FSM capture (busy).
// FSM read port is combinational; ioctl upload port is registered.
module hiscore_buf
  import hiscore_pkg::*;
#(
  parameter int HS_LEN = 16
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       lock,
  input  logic       ioctl_wr,
  input  hs_idx_t    ioctl_addr,
  input  logic [7:0] ioctl_dout,
  output logic [7:0] ioctl_din,
  input  logic       cap_we,
  input  hs_idx_t    cap_idx,
  input  logic [7:0] cap_data,
  input  hs_idx_t    rd_idx,
  output logic [7:0] rd_data
);

  logic [7:0] mem [HS_BUF_MAX];
  logic       in_range;

  assign in_range = int'(ioctl_addr) < HS_LEN;
  assign rd_data  = mem[rd_idx];

  // Storage is deliberately not reset; while a burst owns the buffer only capture may write.
  always_ff @(posedge Clock) begin
    if (lock) begin
      if (cap_we) mem[cap_idx] <= cap_data;
    end else if (ioctl_wr && in_range) begin
      mem[ioctl_addr] <= ioctl_dout;
    end
  end

  // Registered upload read; out-of-range indices read as zero.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)      ioctl_din <= 8'h00;
    else if (in_range) ioctl_din <= mem[ioctl_addr];
    else               ioctl_din <= 8'h00;
  end

endmodule

// File: rtl/hiscore_engine.sv
// Hiscore engine: moves HS_LEN bytes between the local buffer and game RAM
// through the memory block's hiscore port, holding the CPU for the burst.
// Optional build macro HISCORE_VERIFY_EN adds a read-back compare pass after
// restore and the verify_err output.
module hiscore_engine
  import hiscore_pkg::*;
#(
  parameter logic [15:0] HS_BASE   = 16'h20F4,
  parameter int          HS_LEN    = 16,
  parameter int          PAUSE_CYC = 8
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        restore_req,
  input  logic        save_req,
  input  logic        ioctl_wr,
  input  logic [5:0]  ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [7:0]  ioctl_din,
  output logic        hs_access,
  output logic [15:0] hs_address,
  output logic [7:0]  hs_data_in,
  output logic        hs_write,
  input  logic [7:0]  hs_data_out,
  output logic        pause_cpu,
  output logic        busy,
`ifdef HISCORE_VERIFY_EN
  output logic        verify_err,
`endif
  output logic        done
);

  localparam hs_idx_t    LAST  = hs_idx_t'(HS_LEN - 1);
  localparam logic [7:0] PLAST = 8'(PAUSE_CYC - 1);

  hs_state_t  state, state_n;
  hs_idx_t    idx, idx_n;
  logic [7:0] cnt, cnt_n;
  logic       restore, restore_n;  // burst direction: 1 = buffer -> RAM
  logic       vph, vph_n;          // read pass is a verify, not a capture
  logic [7:0] buf_rd;
  logic       cap_we;

  hiscore_buf #(.HS_LEN(HS_LEN)) u_buf (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .lock       (busy),
    .ioctl_wr   (ioctl_wr),
    .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout),
    .ioctl_din  (ioctl_din),
    .cap_we     (cap_we),
    .cap_idx    (idx),
    .cap_data   (hs_data_out),
    .rd_idx     (idx),
    .rd_data    (buf_rd)
  );

  // State and counter registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      restore <= 1'b0;
      vph     <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      restore <= restore_n;
      vph     <= vph_n;
    end
  end

  // Next-state logic; idx is only zeroed when leaving PAUSE so hs_address holds while idle.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    restore_n = restore;
    vph_n     = vph;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (restore_req) begin
          state_n   = PAUSE;
          restore_n = 1'b1;
        end else if (save_req) begin
          state_n   = PAUSE;
          restore_n = 1'b0;
        end
      end
      PAUSE: begin
        if (cnt == PLAST) begin
          idx_n   = '0;
          vph_n   = 1'b0;
          state_n = restore ? WR : RD_ADDR;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      WR: begin
        if (idx == LAST) begin
`ifdef HISCORE_VERIFY_EN
          state_n = RD_ADDR;
          idx_n   = '0;
          vph_n   = 1'b1;
`else
          state_n = DONE;
`endif
        end else begin
          idx_n = idx + 6'd1;
        end
      end
      RD_ADDR: state_n = RD_CAP;
      RD_CAP: begin
        if (idx == LAST) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + 6'd1;
          state_n = RD_ADDR;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign hs_access  = (state == WR) || (state == RD_ADDR) || (state == RD_CAP);
  assign hs_write   = (state == WR);
  assign hs_data_in = (state == WR) ? buf_rd : 8'h00;
  assign hs_address = HS_BASE + {10'b0, idx};
  assign busy       = (state != IDLE);
  assign pause_cpu  = busy;
  assign done       = (state == DONE);
  assign cap_we     = (state == RD_CAP) && !vph;

`ifdef HISCORE_VERIFY_EN
  // Sticky read-back mismatch flag, cleared when the next restore is accepted.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                              verify_err <= 1'b0;
    else if (state == IDLE && restore_req)     verify_err <= 1'b0;
    else if (state == RD_CAP && vph && hs_data_out != buf_rd) verify_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_hiscore_engine.sv
// Directed bench for hiscore_engine with a behavioural game-RAM model.
module tb_hiscore_engine;

`ifdef HISCORE_VERIFY_EN
  localparam int N_RST = 48;
`else
  localparam int N_RST = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restore_req = 1'b0, save_req = 1'b0, ioctl_wr = 1'b0;
  logic [5:0]  ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_din, hs_data_in, hs_data_out;
  logic [15:0] hs_address;
  logic        hs_access, hs_write, pause_cpu, busy, done;
`ifdef HISCORE_VERIFY_EN
  logic        verify_err;
`endif

  logic [7:0]  ram [65536];
  logic        corrupt = 1'b0;
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;

  int n_chk = 0, n_fail = 0;
  int acc, wr, dn, w, k;

  hiscore_engine dut (
    .Clock       (clk),
    .Reset_n     (rst_n),
    .restore_req (restore_req),
    .save_req    (save_req),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_din   (ioctl_din),
    .hs_access   (hs_access),
    .hs_address  (hs_address),
    .hs_data_in  (hs_data_in),
    .hs_write    (hs_write),
    .hs_data_out (hs_data_out),
    .pause_cpu   (pause_cpu),
    .busy        (busy),
`ifdef HISCORE_VERIFY_EN
    .verify_err  (verify_err),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  // Game RAM: write on hs_write, registered read, optional corruption of 20F8, bench preload port.
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (hs_access && hs_write)
      ram[hs_address] <= (corrupt && hs_address == 16'h20F8) ? ~hs_data_in : hs_data_in;
    hs_data_out <= ram[hs_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ram_fill(input logic [7:0] base_val, input logic step);
    for (int i = 0; i < 16; i++) begin
      ld_en = 1'b1; ld_addr = 16'h20F4 + 16'(i); ld_data = base_val + (step ? 8'(i) : 8'h00);
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic pulse_restore();
    restore_req = 1'b1; tick(); restore_req = 1'b0;
  endtask

  // Runs until done (bounded) counting access and write cycles.
  task automatic burst(output int a, output int wcnt, output int d);
    a = 0; wcnt = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (hs_access) a++;
      if (hs_write) wcnt++;
      tick();
    end
    d = int'(done);
  endtask

  initial begin
    // 1: reset state
    #12;
    chk("rst_access", hs_access, 0);
    chk("rst_pause", pause_cpu, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_din", ioctl_din, 8'h00);
    chk("rst_addr", hs_address, 16'h20F4);

    // 2: download 01..10, restore, watch the port cycle by cycle
    for (int i = 0; i < 16; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 6'(i); ioctl_dout = 8'(i + 1);
      tick();
    end
    ioctl_wr = 1'b0;
    pulse_restore();
    chk("pause_rise", pause_cpu, 1);
    chk("pause_no_access", hs_access, 0);
    w = 0;
    while (!hs_access && w < 50) begin tick(); w++; end
    chk("pause_len", w, 8);
    k = 0;
    while (hs_access && k < 100) begin
      if (k < 16) begin
        chk("wr_addr", hs_address, 16'h20F4 + 16'(k));
        chk("wr_data", hs_data_in, 8'(k + 1));
        chk("wr_we", hs_write, 1);
      end else begin
        chk("verify_no_we", hs_write, 0);
      end
      k++; tick();
    end
    chk("restore_access_len", k, N_RST);
    chk("done_pulse", done, 1);
    chk("done_pause", pause_cpu, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_pause", pause_cpu, 0);
    for (int i = 0; i < 16; i++) chk("ram_restore", ram[16'h20F4 + 16'(i)], 8'(i + 1));

    // 3: save A0..AF from RAM, then upload
    ram_fill(8'hA0, 1'b1);
    save_req = 1'b1; tick(); save_req = 1'b0;
    burst(acc, wr, dn);
    chk("save_done", dn, 1);
    chk("save_access_len", acc, 32);
    chk("save_no_write", wr, 0);
    tick();
    chk("addr_hold", hs_address, 16'h2103);
    for (int i = 0; i < 16; i++) begin
      ioctl_addr = 6'(i); tick();
      chk("upload", ioctl_din, 8'hA0 + 8'(i));
    end

    // 4a: simultaneous requests -> restore only
    ram_fill(8'h00, 1'b0);
    restore_req = 1'b1; save_req = 1'b1; tick(); restore_req = 1'b0; save_req = 1'b0;
    burst(acc, wr, dn);
    chk("both_done", dn, 1);
    chk("both_writes", wr, 16);
    chk("both_access", acc, N_RST);
    chk("both_ram0", ram[16'h20F4], 8'hA0);
    chk("both_ramF", ram[16'h2103], 8'hAF);
    tick();

    // 4b: save_req during a burst is ignored
    pulse_restore();
    for (int i = 0; i < 10; i++) tick();
    save_req = 1'b1; tick(); save_req = 1'b0;
    burst(acc, wr, dn);
    chk("ign_done", dn, 1);
    tick(); tick(); tick();
    chk("ign_busy", busy, 0);
    chk("ign_access", hs_access, 0);

    // 4c: out-of-range download discarded
    ioctl_wr = 1'b1; ioctl_addr = 6'd20; ioctl_dout = 8'h55; tick();
    ioctl_wr = 1'b0; tick();
    chk("oor_din", ioctl_din, 8'h00);
    ioctl_addr = 6'd4; tick();
    chk("oor_nochange", ioctl_din, 8'hA4);

    // 5: reset in the 5th WR cycle
    pulse_restore();
    w = 0;
    while (!hs_access && w < 50) begin tick(); w++; end
    for (int i = 0; i < 4; i++) tick();
    chk("mid_addr", hs_address, 16'h20F8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_access", hs_access, 0);
    chk("arst_write", hs_write, 0);
    chk("arst_pause", pause_cpu, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle", busy, 0);
    pulse_restore();
    burst(acc, wr, dn);
    chk("arst_restart_done", dn, 1);
    chk("arst_restart_writes", wr, 16);
    tick();

`ifdef HISCORE_VERIFY_EN
    // 6: corrupted byte flagged, clean restore clears it
    corrupt = 1'b1;
    pulse_restore();
    burst(acc, wr, dn);
    chk("ver_done", dn, 1);
    tick();
    chk("ver_err_set", verify_err, 1);
    corrupt = 1'b0;
    pulse_restore();
    chk("ver_err_clr", verify_err, 0);
    burst(acc, wr, dn);
    tick();
    chk("ver_err_clean", verify_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
